// File: rtl/prescaled_counter_pkg.sv
// prescaled_counter_pkg
//   Shared constants and helpers for the prescaled counter slice.
//   div_of()   : clock-to-tick division ratio (guards a zero tick rate)
//   DIR_*      : encodings of the dir input
//   MODE_*     : encodings of the sat input
package prescaled_counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Number of clk cycles per tick.
  function automatic int unsigned div_of(input int unsigned clk_f,
                                         input int unsigned tick_f);
    return (tick_f == 32'd0) ? 32'd1 : clk_f / tick_f;
  endfunction

endpackage

// File: rtl/prescaled_counter_if.sv
// prescaled_counter_if
//   Control/status bundle of the prescaled counter.
//   master : drives clr, en, dir, sat, load, load_val; observes tick, count, tc, carry
//   slave  : the counter side of the same signals
interface prescaled_counter_if #(
  parameter int unsigned CNT_W = 4
);

  logic             clr;
  logic             en;
  logic             dir;
  logic             sat;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             tick;
  logic [CNT_W-1:0] count;
  logic             tc;
  logic             carry;

  modport master (
    output clr, en, dir, sat, load, load_val,
    input  tick, count, tc, carry
  );

  modport slave (
    input  clr, en, dir, sat, load, load_val,
    output tick, count, tc, carry
  );

endinterface

// File: rtl/prescaled_counter_tick_gen.sv
// tick_gen
//   Prescaler: divides clk by CLK_FREQ/TICK_FREQ into a one-cycle enable tick.
//   clk, rst (async, active-high) : clock / reset
//   i_clr  : synchronous clear of the phase counter
//   i_en   : run enable; phase holds while low
//   o_tick : en && phase == DIV-1
module tick_gen
  import prescaled_counter_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned TICK_FREQ = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned DIV   = div_of(CLK_FREQ, TICK_FREQ);
  localparam int unsigned DIV_W = (DIV > 32'd1) ? 32'($clog2(DIV)) : 32'd1;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 32'd1);

  logic [DIV_W-1:0] r_div_cnt;
  logic             w_at_last;

  // With DIV==1 LAST is 0, the register never leaves 0 and the tick equals en.
  assign w_at_last = (r_div_cnt == LAST);
  assign o_tick    = i_en && w_at_last;

  // Phase counter; holding while disabled preserves the phase across pauses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else if (i_clr) begin
      r_div_cnt <= '0;
    end else if (i_en) begin
      r_div_cnt <= w_at_last ? '0 : r_div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/prescaled_counter.sv
// prescaled_counter
//   Prescaler plus modulo CNT_MAX+1 up/down counter, single clock domain.
//   clk, rst (async, active-high) : clock / reset
//   bus.clr, bus.en, bus.dir, bus.sat, bus.load, bus.load_val : controls
//   bus.tick  : one-cycle enable pulse every DIV enabled cycles
//   bus.count : registered count
//   bus.tc    : terminal count for the current direction (combinational on dir)
//   bus.carry : registered one-cycle pulse coincident with a wrapped count
module prescaled_counter
  import prescaled_counter_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned TICK_FREQ = 1,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned CNT_MAX   = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  prescaled_counter_if.slave    bus
);

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(CNT_MAX);

  // Parameter sanity checks at elaboration.
  if (TICK_FREQ == 32'd0) begin : g_err_tick_zero
    $error("prescaled_counter: TICK_FREQ must be non-zero");
  end else if ((TICK_FREQ > CLK_FREQ) || ((CLK_FREQ % TICK_FREQ) != 32'd0)) begin : g_err_ratio
    $error("prescaled_counter: CLK_FREQ must be a multiple of TICK_FREQ");
  end
  if (64'(CNT_MAX) >= (64'd1 << CNT_W)) begin : g_err_max
    $error("prescaled_counter: CNT_MAX does not fit in CNT_W bits");
  end

  logic             w_tick;
  logic [CNT_W-1:0] w_load_clamped;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_carry_nxt;
  logic [CNT_W-1:0] r_count;
  logic             r_carry;

  tick_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .TICK_FREQ (TICK_FREQ)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (bus.clr),
    .i_en   (bus.en),
    .o_tick (w_tick)
  );

  // Loads are clamped so the count can never leave 0..CNT_MAX.
  assign w_load_clamped = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;

  // Next count: clr > load > tick > hold; carry only on a wrapping tick.
  always_comb begin
    w_count_nxt = r_count;
    w_carry_nxt = 1'b0;
    if (bus.clr) begin
      w_count_nxt = '0;
    end else if (bus.load) begin
      w_count_nxt = w_load_clamped;
    end else if (w_tick) begin
      if (bus.dir == DIR_UP) begin
        if (r_count != MAX_V) begin
          w_count_nxt = r_count + 1'b1;
        end else if (bus.sat == MODE_WRAP) begin
          w_count_nxt = '0;
          w_carry_nxt = 1'b1;
        end
      end else begin
        if (r_count != '0) begin
          w_count_nxt = r_count - 1'b1;
        end else if (bus.sat == MODE_WRAP) begin
          w_count_nxt = MAX_V;
          w_carry_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_carry <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_carry <= w_carry_nxt;
    end
  end

  assign bus.tick  = w_tick;
  assign bus.count = r_count;
  assign bus.carry = r_carry;
  assign bus.tc    = (bus.dir == DIR_UP) ? (r_count == MAX_V) : (r_count == '0);

endmodule

// File: tb/tb_prescaled_counter.sv
// tb_prescaled_counter
//   Scoreboard bench: a cycle model pushes the expected post-edge outputs,
//   each scenario task pops and compares them against the DUT, plus fixed
//   checkpoints derived by hand from the DIV=10 / CNT_MAX=9 configuration.
module tb_prescaled_counter;

  localparam int CW   = 4;
  localparam int CMAX = 9;
  localparam int DIVV = 10;

  typedef struct packed {
    logic          tick;
    logic [CW-1:0] count;
    logic          tc;
    logic          carry;
  } obs_t;

  logic clk = 1'b0;
  logic rst;

  prescaled_counter_if #(.CNT_W(CW)) bus ();
  prescaled_counter_if #(.CNT_W(CW)) bus1 ();

  prescaled_counter #(
    .CLK_FREQ(10), .TICK_FREQ(1), .CNT_W(CW), .CNT_MAX(CMAX)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  prescaled_counter #(
    .CLK_FREQ(4), .TICK_FREQ(4), .CNT_W(CW), .CNT_MAX(CMAX)
  ) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  obs_t exp_q[$];
  int   m_ph;
  int   m_cnt;
  bit   m_carry;

  function automatic obs_t observe();
    obs_t o;
    o.tick  = bus.tick;
    o.count = bus.count;
    o.tc    = bus.tc;
    o.carry = bus.carry;
    return o;
  endfunction

  // Advance the model by one edge using the current inputs, then one clock.
  task automatic cycle();
    bit   t;
    obs_t e;
    t = bus.en && (m_ph == DIVV - 1);
    if (bus.clr) begin
      m_ph = 0; m_cnt = 0; m_carry = 0;
    end else begin
      if (bus.en) m_ph = (m_ph + 1) % DIVV;
      m_carry = 0;
      if (bus.load) begin
        m_cnt = (int'(bus.load_val) > CMAX) ? CMAX : int'(bus.load_val);
      end else if (t) begin
        if (bus.dir) begin
          if (m_cnt < CMAX) m_cnt = m_cnt + 1;
          else if (!bus.sat) begin m_cnt = 0; m_carry = 1; end
        end else begin
          if (m_cnt > 0) m_cnt = m_cnt - 1;
          else if (!bus.sat) begin m_cnt = CMAX; m_carry = 1; end
        end
      end
    end
    @(posedge clk);
    #1;
    e.tick  = bus.en && (m_ph == DIVV - 1);
    e.count = CW'(m_cnt);
    e.tc    = bus.dir ? (m_cnt == CMAX) : (m_cnt == 0);
    e.carry = m_carry;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_ph = 0; m_cnt = 0; m_carry = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    obs_t o;
    #2 rst = 1'b1;
    #1;
    o = observe();
    n_tests++;
    if (o !== obs_t'({1'b0, 4'd0, 1'b0, 1'b0})) begin
      n_fail++; $display("FAIL reset_async: got %b want %b", o, 7'b0000000);
    end
    bus.dir = 1'b0;
    #1;
    n_tests++;
    if (bus.tc !== 1'b1) begin
      n_fail++; $display("FAIL reset_tc_down: got %b want 1", bus.tc);
    end
    bus.dir = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_count_up();
    obs_t o, e;
    bus.en = 1'b1; bus.dir = 1'b1; bus.sat = 1'b0;
    for (int i = 1; i <= 101; i++) begin
      cycle();
      e = exp_q.pop_front(); o = observe();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL up[%0d]: got %b want %b", i, o, e); end
      if (i == 90) begin
        n_tests++;
        if (o.count !== 4'd9 || o.tc !== 1'b1) begin
          n_fail++; $display("FAIL up_tc9: got count=%0d tc=%b want 9/1", o.count, o.tc);
        end
      end
      if (i == 100 || i == 101) begin
        n_tests++;
        if (o.count !== 4'd0 || o.carry !== (i == 100)) begin
          n_fail++; $display("FAIL up_wrap[%0d]: got count=%0d carry=%b", i, o.count, o.carry);
        end
      end
    end
  endtask

  task automatic test_count_down();
    obs_t o, e;
    logic [3:0] want;
    bus.dir = 1'b0;
    for (int i = 1; i <= 29; i++) begin
      cycle();
      e = exp_q.pop_front(); o = observe();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL down[%0d]: got %b want %b", i, o, e); end
      if (i == 9 || i == 10 || i == 19 || i == 29) begin
        want = (i == 19) ? 4'd8 : (i == 29) ? 4'd7 : 4'd9;
        n_tests++;
        if (o.count !== want || o.carry !== (i == 9)) begin
          n_fail++; $display("FAIL down_pt[%0d]: got count=%0d carry=%b want %0d", i, o.count, o.carry, want);
        end
      end
    end
  endtask

  task automatic test_saturate();
    obs_t o, e;
    bit   seen_carry;
    seen_carry = 0;
    bus.dir = 1'b1; bus.sat = 1'b1; bus.load = 1'b1; bus.load_val = 4'd9;
    for (int i = 0; i < 31; i++) begin
      cycle();
      bus.load = 1'b0;
      e = exp_q.pop_front(); o = observe();
      if (o.carry) seen_carry = 1;
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL sat[%0d]: got %b want %b", i, o, e); end
    end
    n_tests++;
    if (bus.count !== 4'd9 || bus.tc !== 1'b1 || seen_carry) begin
      n_fail++; $display("FAIL sat_hold: got count=%0d tc=%b carry_seen=%b want 9/1/0", bus.count, bus.tc, seen_carry);
    end
    bus.sat = 1'b0;
  endtask

  task automatic test_load();
    obs_t o, e;
    bus.load = 1'b1; bus.load_val = 4'd12;
    cycle();
    bus.load = 1'b0;
    e = exp_q.pop_front(); o = observe();
    n_tests++;
    if (o !== e || o.count !== 4'd9) begin n_fail++; $display("FAIL load_clamp: got %b want %b", o, e); end
    for (int i = 0; i < 20 && m_ph != DIVV - 1; i++) begin
      cycle();
      e = exp_q.pop_front(); o = observe();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL load_wait[%0d]: got %b want %b", i, o, e); end
    end
    n_tests++;
    if (bus.tick !== 1'b1) begin n_fail++; $display("FAIL load_tick_edge: got tick=%b want 1", bus.tick); end
    bus.load = 1'b1; bus.load_val = 4'd3;
    cycle();
    bus.load = 1'b0;
    e = exp_q.pop_front(); o = observe();
    n_tests++;
    if (o !== e || o.count !== 4'd3 || o.carry !== 1'b0) begin
      n_fail++; $display("FAIL load_wins: got %b want %b", o, e);
    end
  endtask

  task automatic test_pause();
    obs_t o, e;
    logic [3:0] held;
    int k;
    for (int i = 0; i < 20 && m_ph != 4; i++) begin
      cycle();
      void'(exp_q.pop_front());
    end
    held = bus.count;
    bus.en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cycle();
      e = exp_q.pop_front(); o = observe();
      n_tests++;
      if (o !== e || o.count !== held) begin n_fail++; $display("FAIL pause[%0d]: got %b want %b", i, o, e); end
    end
    bus.en = 1'b1;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      e = exp_q.pop_front(); o = observe();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL resume[%0d]: got %b want %b", i, o, e); end
      if (o.tick) begin k = i; break; end
    end
    n_tests++;
    if (k != 5) begin n_fail++; $display("FAIL resume_phase: got tick after %0d cycles want 5", k); end
  endtask

  task automatic test_async_reset();
    obs_t o, e;
    int k;
    bus.load = 1'b1; bus.load_val = 4'd6;
    cycle();
    bus.load = 1'b0;
    e = exp_q.pop_front(); o = observe();
    n_tests++;
    if (o !== e || o.count !== 4'd6) begin n_fail++; $display("FAIL rst_pre: got %b want %b", o, e); end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (bus.count !== 4'd0 || bus.carry !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid: got count=%0d carry=%b want 0/0", bus.count, bus.carry);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      e = exp_q.pop_front(); o = observe();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL rst_run[%0d]: got %b want %b", i, o, e); end
      if (o.tick) begin k = i; break; end
    end
    n_tests++;
    if (k != DIVV - 1) begin n_fail++; $display("FAIL rst_first_tick: got %0d want %0d", k, DIVV - 1); end
  endtask

  task automatic test_clear();
    obs_t o, e;
    int k;
    bus.load = 1'b1; bus.load_val = 4'd5;
    cycle();
    bus.load = 1'b0;
    void'(exp_q.pop_front());
    repeat (3) begin cycle(); void'(exp_q.pop_front()); end
    bus.clr = 1'b1;
    cycle();
    bus.clr = 1'b0;
    e = exp_q.pop_front(); o = observe();
    n_tests++;
    if (o !== e || o.count !== 4'd0) begin n_fail++; $display("FAIL clr: got %b want %b", o, e); end
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      e = exp_q.pop_front(); o = observe();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL clr_run[%0d]: got %b want %b", i, o, e); end
      if (o.tick) begin k = i; break; end
    end
    n_tests++;
    if (k != DIVV - 1) begin n_fail++; $display("FAIL clr_phase: got %0d want %0d", k, DIVV - 1); end
  endtask

  task automatic test_div1();
    int  c1;
    bit  en1, wrap;
    c1 = int'(bus1.count);
    n_tests++;
    if (c1 != 0) begin n_fail++; $display("FAIL div1_idle: got count=%0d want 0", c1); end
    for (int i = 0; i < 26; i++) begin
      en1 = (i < 22) || (i == 24);
      bus1.en = en1;
      #1;
      n_tests++;
      if (bus1.tick !== en1) begin n_fail++; $display("FAIL div1_tick[%0d]: got %b want %b", i, bus1.tick, en1); end
      wrap = en1 && (c1 == CMAX);
      if (en1) c1 = (c1 == CMAX) ? 0 : c1 + 1;
      @(posedge clk);
      #1;
      n_tests++;
      if (bus1.count !== CW'(c1) || bus1.carry !== wrap) begin
        n_fail++; $display("FAIL div1_cnt[%0d]: got count=%0d carry=%b want %0d/%b", i, bus1.count, bus1.carry, c1, wrap);
      end
    end
    bus1.en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, failed=%0d", n_fail);
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    bus.clr = 1'b0; bus.en = 1'b0; bus.dir = 1'b1; bus.sat = 1'b0;
    bus.load = 1'b0; bus.load_val = '0;
    bus1.clr = 1'b0; bus1.en = 1'b0; bus1.dir = 1'b1; bus1.sat = 1'b0;
    bus1.load = 1'b0; bus1.load_val = '0;
    model_reset();
    test_reset();
    test_count_up();
    test_count_down();
    test_saturate();
    test_load();
    test_pause();
    test_async_reset();
    test_clear();
    test_div1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
